// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   UART receive frame engine. Oversamples RX_IN at PRESCALE clocks per bit,
//   detects the start bit, shifts in DATA_WIDTH bits LSB first, checks optional
//   even/odd parity and the stop bit. Good words are presented on P_DATA with a
//   one-cycle DATA_VALID pulse; parity and framing errors pulse PAR_ERR/STP_ERR.
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   RX_IN      asynchronous serial line, idle high
//   PAR_EN     1 = frame carries a parity bit after the data
//   PAR_TYP    0 = even parity, 1 = odd parity
//   P_DATA     last good received word
//   DATA_VALID one-cycle pulse, P_DATA updated this cycle
//   PAR_ERR    one-cycle pulse, parity mismatch
//   STP_ERR    one-cycle pulse, stop bit sampled 0
module uart_rx_frame #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] E_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] E_DEC  = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;

  logic                  sync1, rx_s;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  s_a, s_b;
  logic                  maj;
  logic                  dec, last;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q, par_typ_q, par_bad;
  logic                  start_frame, finish;

  // Two-flop synchronizer; idle-high reset value so reset never looks like a start edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      rx_s  <= sync1;
    end
  end

  // Majority of the three mid-bit samples; the third is taken live at the decision edge.
  assign maj  = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign dec  = (edge_cnt == E_DEC);
  assign last = (edge_cnt == E_LAST);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n     = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (dec && maj)  state_n = IDLE;
        else if (last)   state_n = DATA;
      end
      DATA: begin
        if (last && (bit_cnt == B_LAST)) state_n = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (last) state_n = STOP;
      end
      STOP: begin
        // Leave mid-stop-bit so the next start edge can be caught with no idle gap.
        if (dec) begin
          state_n = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      s_a        <= 1'b1;
      s_b        <= 1'b1;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;

      // The IDLE cycle that sees rx_s low counts as edge 0 of the start bit.
      if (state_n == IDLE)     edge_cnt <= '0;
      else if (state == IDLE)  edge_cnt <= EW'(1);
      else if (last)           edge_cnt <= '0;
      else                     edge_cnt <= edge_cnt + EW'(1);

      if (state != DATA)       bit_cnt <= '0;
      else if (last)           bit_cnt <= bit_cnt + BW'(1);

      if (edge_cnt == E_S0) s_a <= rx_s;
      if (edge_cnt == E_S1) s_b <= rx_s;

      if (start_frame) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_bad   <= 1'b0;
      end

      // Right shift: after DATA_WIDTH bits the first bit received sits at bit 0.
      if ((state == DATA) && dec) shreg <= {maj, shreg[DATA_WIDTH-1:1]};

      if ((state == PARITY) && dec) par_bad <= (maj != ((^shreg) ^ par_typ_q));

      if (finish) begin
        DATA_VALID <= maj & ~par_bad;
        PAR_ERR    <= par_bad;
        STP_ERR    <= ~maj;
        if (maj && !par_bad) P_DATA <= shreg;
      end
    end
  end

endmodule
